raw_bayer_gray: RTL and testbench

RAW_BAYER_GRAY -- requirements
Module: raw_bayer_gray

---
 rtl/imgproc_pkg.sv | 17 +
 rtl/bayer_line_ram.sv | 32 +++
 rtl/raw_bayer_gray.sv | 184 ++++++++++++++++++
 tb/tb_raw_bayer_gray.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imgproc_pkg.sv
// Shared image-processing types and widths used by the Bayer-to-gray path.
package imgproc_pkg;

    localparam int PIX_W   = 12;
    localparam int COORD_W = 16;

    // Four 12-bit pixels summed without overflow need two extra bits.
    localparam int SUM_W   = PIX_W + 2;

    // One gray output sample; is_edge marks the half-resolution frame border.
    typedef struct packed {
        logic [PIX_W-1:0] value;
        logic             is_edge;
        logic             valid;
    } gray_pix_t;

endpackage

// File: rtl/bayer_line_ram.sv
// Single-port line buffer holding one even raw row; one-cycle registered read.
module bayer_line_ram
    import imgproc_pkg::*;
#(
    parameter int DEPTH = 1280,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wdata,
    output logic [PIX_W-1:0] rdata
);

    logic [PIX_W-1:0] mem [DEPTH];
    logic [PIX_W-1:0] rdata_q;

    // Write or read one word per enabled cycle; read data holds between reads.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/raw_bayer_gray.sv
// Averages each 2x2 Bayer quad into one half-resolution gray pixel.
// The even row of a quad pair is parked in a line RAM; the odd row combines
// with it. Because the RAM has a single port, the top-left pixel is fetched
// on the odd-row even-column cycle and the top-right on the completing cycle.
module raw_bayer_gray
    import imgproc_pkg::*;
#(
    parameter int LINE_W  = 1280,
    parameter int FRAME_H = 960
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic [PIX_W-1:0]   iDATA,
    input  logic               iDVAL,
    input  logic [COORD_W-1:0] iX_Cont,
    input  logic [COORD_W-1:0] iY_Cont,
    output logic [PIX_W-1:0]   oGRAY,
    output logic               oEDGE,
    output logic               oDVAL,
    output logic [COORD_W-1:0] oX,
    output logic [COORD_W-1:0] oY
);

    localparam int                 AW         = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam logic [COORD_W:0]   LINE_LIMIT = (COORD_W+1)'(LINE_W);
    localparam logic [COORD_W-1:0] X_LAST     = COORD_W'(LINE_W / 2 - 1);
    localparam logic [COORD_W-1:0] Y_LAST     = COORD_W'(FRAME_H / 2 - 1);

    logic               pix_ok;
    logic               odd_row;
    logic               odd_col;
    logic               row_match;
    logic               hold_evt;
    logic               done_evt;
    logic               ram_en;
    logic               ram_we;
    logic [AW-1:0]      ram_addr;
    logic [PIX_W-1:0]   ram_rdata;
    logic [SUM_W-1:0]   quad_sum;

    logic [PIX_W-1:0]   hold_q, hold_d;
    logic               hold_vld_q, hold_vld_d;
    logic               primed_q, primed_d;
    logic [COORD_W-2:0] primed_row_q, primed_row_d;
    logic               tl_pend_q, tl_pend_d;
    logic [PIX_W-1:0]   tl_q, tl_d;
    logic [PIX_W-1:0]   bl_q, bl_d;
    logic [PIX_W-1:0]   br_q, br_d;
    logic               s1_vld_q, s1_vld_d;
    logic [COORD_W-1:0] s1_x_q, s1_x_d;
    logic [COORD_W-1:0] s1_y_q, s1_y_d;
    gray_pix_t          out_q, out_d;
    logic [COORD_W-1:0] ox_q, ox_d;
    logic [COORD_W-1:0] oy_q, oy_d;

    // Classify the incoming pixel and steer the single RAM port.
    always_comb begin
        pix_ok    = iDVAL && ({1'b0, iX_Cont} < LINE_LIMIT);
        odd_row   = iY_Cont[0];
        odd_col   = iX_Cont[0];
        row_match = primed_q && (iY_Cont[COORD_W-1:1] == primed_row_q);
        hold_evt  = pix_ok && odd_row && !odd_col;
        done_evt  = pix_ok && odd_row && odd_col && hold_vld_q && row_match;
        ram_en    = pix_ok && !iRST;
        ram_we    = !odd_row;
        ram_addr  = iX_Cont[AW-1:0];
    end

    bayer_line_ram #(
        .DEPTH (LINE_W),
        .AW    (AW)
    ) u_line_ram (
        .clk   (iCLK),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (iDATA),
        .rdata (ram_rdata)
    );

    assign quad_sum = SUM_W'(tl_q) + SUM_W'(ram_rdata) + SUM_W'(bl_q) + SUM_W'(br_q);

    // Next state: row tracking, quad capture, then sum and output registers.
    always_comb begin
        hold_d       = hold_q;
        hold_vld_d   = hold_vld_q;
        primed_d     = primed_q;
        primed_row_d = primed_row_q;
        tl_pend_d    = 1'b0;
        tl_d         = tl_q;
        bl_d         = bl_q;
        br_d         = br_q;
        s1_vld_d     = 1'b0;
        s1_x_d       = s1_x_q;
        s1_y_d       = s1_y_q;
        out_d        = out_q;
        out_d.valid  = 1'b0;
        ox_d         = ox_q;
        oy_d         = oy_q;

        if (pix_ok) begin
            if (!odd_row) begin
                primed_d     = 1'b1;
                primed_row_d = iY_Cont[COORD_W-1:1];
                hold_vld_d   = 1'b0;
            end else begin
                if (!row_match) begin
                    primed_d = 1'b0;
                end
                if (!odd_col) begin
                    hold_d     = iDATA;
                    hold_vld_d = 1'b1;
                    tl_pend_d  = 1'b1;
                end else begin
                    hold_vld_d = 1'b0;
                end
            end
        end

        if (done_evt) begin
            s1_vld_d = 1'b1;
            bl_d     = hold_q;
            br_d     = iDATA;
            s1_x_d   = {1'b0, iX_Cont[COORD_W-1:1]};
            s1_y_d   = {1'b0, iY_Cont[COORD_W-1:1]};
        end

        if (tl_pend_q) begin
            tl_d = ram_rdata;
        end

        if (s1_vld_q) begin
            out_d.value   = quad_sum[SUM_W-1:2];
            out_d.is_edge = (s1_x_q == '0) || (s1_x_q == X_LAST) ||
                            (s1_y_q == '0) || (s1_y_q == Y_LAST);
            out_d.valid   = 1'b1;
            ox_d          = s1_x_q;
            oy_d          = s1_y_q;
        end
    end

    // State registers; reset drops any quad in flight and forgets the primed row.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            hold_q       <= '0;
            hold_vld_q   <= 1'b0;
            primed_q     <= 1'b0;
            primed_row_q <= '0;
            tl_pend_q    <= 1'b0;
            tl_q         <= '0;
            bl_q         <= '0;
            br_q         <= '0;
            s1_vld_q     <= 1'b0;
            s1_x_q       <= '0;
            s1_y_q       <= '0;
            out_q        <= '0;
            ox_q         <= '0;
            oy_q         <= '0;
        end else begin
            hold_q       <= hold_d;
            hold_vld_q   <= hold_vld_d;
            primed_q     <= primed_d;
            primed_row_q <= primed_row_d;
            tl_pend_q    <= tl_pend_d;
            tl_q         <= tl_d;
            bl_q         <= bl_d;
            br_q         <= br_d;
            s1_vld_q     <= s1_vld_d;
            s1_x_q       <= s1_x_d;
            s1_y_q       <= s1_y_d;
            out_q        <= out_d;
            ox_q         <= ox_d;
            oy_q         <= oy_d;
        end
    end

    // Outputs read zero for the whole time reset is held, not just after the edge.
    assign oGRAY = iRST ? '0 : out_q.value;
    assign oEDGE = !iRST && out_q.is_edge;
    assign oDVAL = !iRST && out_q.valid;
    assign oX    = iRST ? '0 : ox_q;
    assign oY    = iRST ? '0 : oy_q;

endmodule

// File: tb/tb_raw_bayer_gray.sv
// Randomized scoreboard bench for raw_bayer_gray with a quad-averaging model.
module tb_raw_bayer_gray;

    localparam int LW = 8;
    localparam int FH = 4;
    localparam int ROWS = 8;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic [11:0] iDATA = '0;
    logic        iDVAL = 1'b0;
    logic [15:0] iX_Cont = '0;
    logic [15:0] iY_Cont = '0;
    logic [11:0] oGRAY;
    logic        oEDGE;
    logic        oDVAL;
    logic [15:0] oX;
    logic [15:0] oY;

    raw_bayer_gray #(
        .LINE_W  (LW),
        .FRAME_H (FH)
    ) dut (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .iDATA   (iDATA),
        .iDVAL   (iDVAL),
        .iX_Cont (iX_Cont),
        .iY_Cont (iY_Cont),
        .oGRAY   (oGRAY),
        .oEDGE   (oEDGE),
        .oDVAL   (oDVAL),
        .oX      (oX),
        .oY      (oY)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    typedef struct {
        int gray;
        int edge_f;
        int x;
        int y;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   passed = 0;
    int   pulses_seen = 0;
    int   pulses_expected = 0;
    int   last_gray = 0, last_edge = 0, last_x = 0, last_y = 0;

    // Reference model state: the last even row seen and the pending bottom-left pixel.
    int   line_m[LW];
    bit   primed_m = 1'b0;
    int   prow_m = 0;
    bit   hold_ok_m = 1'b0;
    int   hold_m = 0;
    int   frame_v[ROWS][LW];

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    endtask

    // Quad average from the raw pixel rules; pushes an expectation per completed quad.
    task automatic model_pixel(input int x, input int y, input int d);
        bit   rok;
        exp_t e;
        if (x >= LW) return;
        if (y % 2 == 0) begin
            line_m[x] = d;
            primed_m  = 1'b1;
            prow_m    = y;
        end else begin
            rok = primed_m && (y == prow_m + 1);
            if (!rok) primed_m = 1'b0;
            if (x % 2 == 0) begin
                hold_m    = d;
                hold_ok_m = 1'b1;
            end else begin
                if (hold_ok_m && rok) begin
                    e.gray   = (line_m[x-1] + line_m[x] + hold_m + d) / 4;
                    e.x      = x / 2;
                    e.y      = y / 2;
                    e.edge_f = (e.x == 0 || e.x == LW/2 - 1 || e.y == 0 || e.y == FH/2 - 1) ? 1 : 0;
                    e.cyc    = cyc + 2;
                    exp_q.push_back(e);
                    pulses_expected++;
                end
                hold_ok_m = 1'b0;
            end
        end
    endtask

    task automatic apply_stimulus(input bit v, input int x, input int y, input int d);
        @(posedge iCLK);
        #1;
        iDVAL   = v;
        iX_Cont = 16'(x);
        iY_Cont = 16'(y);
        iDATA   = 12'(d);
        if (v) model_pixel(x, y, d);
    endtask

    task automatic apply_gap();
        apply_stimulus(1'b0, $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 4095));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_gap();
    endtask

    // mode 0: gap-free, 1: gap after every pixel, 2: random gaps and out-of-line pixels.
    task automatic send_row(input int y, input int mode);
        for (int x = 0; x < LW; x++) begin
            if (mode == 2 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            if (mode == 2 && $urandom_range(0, 7) == 0)
                apply_stimulus(1'b1, $urandom_range(LW, 2*LW - 1), $urandom_range(0, 7), $urandom_range(0, 4095));
            apply_stimulus(1'b1, x, y, frame_v[y][x]);
            if (mode == 1) apply_gap();
        end
    endtask

    // Reset with a valid pixel presented alongside, which must be ignored.
    task automatic do_reset(input int n);
        @(posedge iCLK);
        #1;
        iRST    = 1'b1;
        iDVAL   = 1'b1;
        iX_Cont = 16'd0;
        iY_Cont = 16'd0;
        iDATA   = 12'(($urandom_range(0, 4095)));
        primed_m  = 1'b0;
        hold_ok_m = 1'b0;
        pulses_expected -= exp_q.size();
        exp_q.delete();
        for (int i = 1; i < n; i++) @(posedge iCLK);
        @(posedge iCLK);
        #1;
        iRST  = 1'b0;
        iDVAL = 1'b0;
    endtask

    task automatic randomize_frame();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < LW; c++)
                frame_v[r][c] = $urandom_range(0, 4095);
    endtask

    // Monitor: pops one expectation per pulse, checks hold behaviour and reset zeros.
    always @(negedge iCLK) begin
        if (iRST) begin
            check_output("reset_outputs", int'(oDVAL) + int'(oEDGE) + int'(oGRAY) + int'(oX) + int'(oY), 0);
            last_gray = 0; last_edge = 0; last_x = 0; last_y = 0;
        end else if (oDVAL) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_dval", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                pulses_seen++;
                check_output("gray", int'(oGRAY), mon_e.gray);
                check_output("edge", int'(oEDGE), mon_e.edge_f);
                check_output("out_x", int'(oX), mon_e.x);
                check_output("out_y", int'(oY), mon_e.y);
                check_output("latency_cycle", cyc, mon_e.cyc);
                last_gray = mon_e.gray; last_edge = mon_e.edge_f;
                last_x = mon_e.x; last_y = mon_e.y;
            end
        end else begin
            if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                check_output("missing_dval", 0, 1);
                void'(exp_q.pop_front());
            end
            check_output("hold_gray", int'(oGRAY), last_gray);
            check_output("hold_edge", int'(oEDGE), last_edge);
            check_output("hold_x", int'(oX), last_x);
            check_output("hold_y", int'(oY), last_y);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int y;
        for (int i = 0; i < LW; i++) line_m[i] = 0;
        do_reset(3);
        idle(2);

        // Uniform 0x800 frame: eight border pulses of 0x800.
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < LW; c++) frame_v[r][c] = 12'h800;
        for (int r = 0; r < 4; r++) send_row(r, 0);
        idle(6);

        // Saturation and truncation quads.
        randomize_frame();
        frame_v[4][0] = 12'hFFF; frame_v[4][1] = 12'hFFF;
        frame_v[5][0] = 12'hFFF; frame_v[5][1] = 12'hFFE;
        frame_v[4][2] = 1; frame_v[4][3] = 1;
        frame_v[5][2] = 1; frame_v[5][3] = 0;
        send_row(4, 0);
        send_row(5, 0);
        idle(6);

        // Odd row first after reset gives nothing; rows 2 and 3 then complete.
        do_reset(2);
        randomize_frame();
        send_row(1, 0);
        send_row(2, 0);
        send_row(3, 0);
        idle(6);

        // Same frame gap-free and with iDVAL toggling every cycle.
        randomize_frame();
        for (int r = 0; r < ROWS; r++) send_row(r, 0);
        idle(4);
        for (int r = 0; r < ROWS; r++) send_row(r, 1);
        idle(6);

        // Reset the cycle after a completing pixel, then a fresh quad pair.
        randomize_frame();
        send_row(0, 0);
        for (int x = 0; x < 4; x++) apply_stimulus(1'b1, x, 1, frame_v[1][x]);
        do_reset(1);
        send_row(0, 0);
        send_row(1, 0);
        idle(6);

        // Random row order, gaps and ignored out-of-line pixels.
        y = 0;
        for (int n = 0; n < 48; n++) begin
            randomize_frame();
            if ($urandom_range(0, 3) == 0) y = $urandom_range(0, ROWS - 1);
            else y = (y + 1) % ROWS;
            send_row(y, 2);
        end
        idle(10);

        check_output("queue_drained", exp_q.size(), 0);
        check_output("pulse_count", pulses_seen, pulses_expected);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
